register_history_bank: RTL and testbench

//   Parametrised successor of the single-stage tri-state register: one NrOfBits-wide register

---
 rtl/memory_pkg.sv | 24 ++
 rtl/history_read_port.sv | 54 +++++
 rtl/register_history_bank.sv | 149 ++++++++++++++
 tb/tb_register_history_bank.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/memory_pkg.sv
// Shared definitions for the memory library: history-bank operation codes
// and a constant-evaluable ceil(log2) used to size index ports.
package memory_pkg;

    localparam logic [1:0] OP_HOLD = 2'b00;
    localparam logic [1:0] OP_PUSH = 2'b01;
    localparam logic [1:0] OP_POP  = 2'b10;
    localparam logic [1:0] OP_REPL = 2'b11;

    // Smallest r with 2**r >= value; at least 1 so index ports never collapse to zero width
    function automatic int clog2(input int value);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((32'sd1 << i) < value) begin
                r = i + 1;
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/history_read_port.sv
// Registered, index-addressed read of one history generation with a
// tri-statable data output. Out-of-range or not-yet-written slots read as zero.
module history_read_port
    import memory_pkg::*;
#(
    parameter int NrOfBits = 8,
    parameter int Depth    = 4,
    parameter int IdxW     = clog2(Depth)
) (
    input  logic                               clk_i,
    input  logic                               rst_n_i,
    input  logic                               cs_i,
    input  logic [IdxW-1:0]                    rd_idx_i,
    input  logic [IdxW:0]                      count_i,
    input  logic [Depth-1:0][NrOfBits-1:0]     entries_i,
    output logic [NrOfBits-1:0]                rd_data_o,
    output logic                               rd_valid_o
);

    localparam logic [IdxW:0] DEPTH_CNT = Depth[IdxW:0];

    logic [IdxW:0]         idx_ext_s;
    logic                  hit_s;
    logic [NrOfBits-1:0]   rd_data_d;
    logic [NrOfBits-1:0]   rd_data_q;
    logic                  rd_valid_q;

    // Select the addressed entry; the range check also guards non-power-of-2 depths
    always_comb begin
        idx_ext_s = {1'b0, rd_idx_i};
        hit_s     = (idx_ext_s < count_i) && (idx_ext_s < DEPTH_CNT);
        rd_data_d = {NrOfBits{1'b0}};
        if (hit_s) begin
            rd_data_d = entries_i[rd_idx_i];
        end else begin
            rd_data_d = {NrOfBits{1'b0}};
        end
    end

    // Read register samples the bank state as it was before this edge's update
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            rd_data_q  <= {NrOfBits{1'b0}};
            rd_valid_q <= 1'b0;
        end else begin
            rd_data_q  <= rd_data_d;
            rd_valid_q <= hit_s;
        end
    end

    assign rd_data_o  = cs_i ? {NrOfBits{1'bz}} : rd_data_q;
    assign rd_valid_o = rd_valid_q;

endmodule

// File: rtl/register_history_bank.sv
// A register that remembers its last Depth generations: push/pop(undo)/replace,
// preset to all-ones, occupancy flags, overflow/underflow pulses and an indexed read.
module register_history_bank
    import memory_pkg::*;
#(
    parameter int NrOfBits = 8,
    parameter int Depth    = 4,
    parameter int IdxW     = clog2(Depth)
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 ClockEnable,
    input  logic                 Tick,
    input  logic                 pre,
    input  logic                 Push,
    input  logic                 Pop,
    input  logic [NrOfBits-1:0]  D,
    input  logic [IdxW-1:0]      RdIdx,
    input  logic                 cs,
    output logic [NrOfBits-1:0]  Q,
    output logic [NrOfBits-1:0]  RdData,
    output logic                 RdValid,
    output logic [IdxW:0]        Count,
    output logic                 Full,
    output logic                 Empty,
    output logic                 Overflow,
    output logic                 Underflow
);

    localparam logic [IdxW:0] DEPTH_CNT = Depth[IdxW:0];
    localparam logic [IdxW:0] CNT_ZERO  = {(IdxW+1){1'b0}};
    localparam logic [IdxW:0] CNT_ONE   = {{IdxW{1'b0}}, 1'b1};

    logic [Depth-1:0][NrOfBits-1:0] hist_q;
    logic [Depth-1:0][NrOfBits-1:0] hist_d;
    logic [IdxW:0]                  count_q;
    logic [IdxW:0]                  count_d;
    logic                           ovf_q;
    logic                           ovf_d;
    logic                           unf_q;
    logic                           unf_d;
    logic                           en_s;
    logic                           full_s;
    logic                           empty_s;
    logic [1:0]                     op_s;

    // Decode the qualified operation; a disabled cycle is an explicit hold
    always_comb begin
        en_s    = ClockEnable & Tick;
        full_s  = (count_q == DEPTH_CNT);
        empty_s = (count_q == CNT_ZERO);
        op_s    = OP_HOLD;
        if (en_s) begin
            op_s = {Pop, Push};
        end else begin
            op_s = OP_HOLD;
        end
    end

    // Next history contents, occupancy and one-shot error pulses
    always_comb begin
        hist_d  = hist_q;
        count_d = count_q;
        ovf_d   = 1'b0;
        unf_d   = 1'b0;
        if (pre) begin
            for (int i = 0; i < Depth; i++) begin
                hist_d[i] = {NrOfBits{1'b1}};
            end
            count_d = DEPTH_CNT;
        end else begin
            case (op_s)
                OP_PUSH: begin
                    for (int i = 1; i < Depth; i++) begin
                        hist_d[i] = hist_q[i-1];
                    end
                    hist_d[0] = D;
                    if (full_s) begin
                        ovf_d = 1'b1;
                    end else begin
                        count_d = count_q + CNT_ONE;
                    end
                end
                OP_POP: begin
                    if (empty_s) begin
                        unf_d = 1'b1;
                    end else begin
                        for (int i = 0; i < Depth - 1; i++) begin
                            hist_d[i] = hist_q[i+1];
                        end
                        hist_d[Depth-1] = {NrOfBits{1'b0}};
                        count_d = count_q - CNT_ONE;
                    end
                end
                OP_REPL: begin
                    // Replace the current value; an empty bank gains its first entry
                    hist_d[0] = D;
                    if (empty_s) begin
                        count_d = CNT_ONE;
                    end else begin
                        count_d = count_q;
                    end
                end
                default: begin
                    hist_d  = hist_q;
                    count_d = count_q;
                end
            endcase
        end
    end

    // Bank state register with synchronous active-low clear
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            hist_q  <= {(Depth*NrOfBits){1'b0}};
            count_q <= CNT_ZERO;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            hist_q  <= hist_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    history_read_port #(
        .NrOfBits (NrOfBits),
        .Depth    (Depth),
        .IdxW     (IdxW)
    ) u_read_port (
        .clk_i      (Clock),
        .rst_n_i    (Reset),
        .cs_i       (cs),
        .rd_idx_i   (RdIdx),
        .count_i    (count_q),
        .entries_i  (hist_q),
        .rd_data_o  (RdData),
        .rd_valid_o (RdValid)
    );

    assign Q         = cs ? {NrOfBits{1'bz}} : hist_q[0];
    assign Count     = count_q;
    assign Full      = full_s;
    assign Empty     = empty_s;
    assign Overflow  = ovf_q;
    assign Underflow = unf_q;

endmodule

// File: tb/tb_register_history_bank.sv
// Self-checking bench for register_history_bank (8 bits, depth 4) against a
// queue-based model holding only the valid generations, newest first.
module tb_register_history_bank;

    localparam int W     = 8;
    localparam int DEPTH = 4;
    localparam int IW    = 2;
    localparam int CW    = 3;

    logic          Clock = 1'b0;
    logic          Reset, ClockEnable, Tick, pre, Push, Pop, cs;
    logic [W-1:0]  D;
    logic [IW-1:0] RdIdx;
    logic [W-1:0]  Q, RdData;
    logic          RdValid, Full, Empty, Overflow, Underflow;
    logic [CW-1:0] Count;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] mq[$];
    logic [W-1:0] exp_rd;
    logic         exp_rv, exp_ovf, exp_unf;

    register_history_bank #(.NrOfBits(W), .Depth(DEPTH)) dut (
        .Clock(Clock), .Reset(Reset), .ClockEnable(ClockEnable), .Tick(Tick),
        .pre(pre), .Push(Push), .Pop(Pop), .D(D), .RdIdx(RdIdx), .cs(cs),
        .Q(Q), .RdData(RdData), .RdValid(RdValid), .Count(Count),
        .Full(Full), .Empty(Empty), .Overflow(Overflow), .Underflow(Underflow)
    );

    always #5 Clock = ~Clock;

    // One clock edge: advance the model from the inputs present at the edge
    task automatic tick();
        @(posedge Clock);
        if (!Reset) begin
            mq.delete();
            exp_rd = 8'h00; exp_rv = 1'b0; exp_ovf = 1'b0; exp_unf = 1'b0;
        end else begin
            exp_rv  = (int'(RdIdx) < mq.size());
            exp_rd  = exp_rv ? mq[RdIdx] : 8'h00;
            exp_ovf = 1'b0; exp_unf = 1'b0;
            if (pre) begin
                mq.delete();
                repeat (DEPTH) mq.push_back(8'hFF);
            end else if (ClockEnable && Tick) begin
                if (Push && Pop) begin
                    if (mq.size() == 0) mq.push_back(D);
                    else mq[0] = D;
                end else if (Push) begin
                    if (mq.size() == DEPTH) begin
                        void'(mq.pop_back());
                        exp_ovf = 1'b1;
                    end
                    mq.push_front(D);
                end else if (Pop) begin
                    if (mq.size() == 0) exp_unf = 1'b1;
                    else void'(mq.pop_front());
                end
            end
        end
        #1;
    endtask

    task automatic idle();
        pre = 1'b0; Push = 1'b0; Pop = 1'b0; ClockEnable = 1'b1; Tick = 1'b1; cs = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b0; idle(); D = 8'h00; RdIdx = 2'd0;
        tick();
        checks += 5;
        if (Count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", Count); end
        if (Empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", Empty); end
        if (Full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", Full); end
        if (Q !== 8'h00) begin failures++; $display("FAIL reset_q got=%h exp=00", Q); end
        if (RdValid !== 1'b0) begin failures++; $display("FAIL reset_rdvalid got=%b exp=0", RdValid); end
        Reset = 1'b1;
        tick();
        checks += 2;
        if (RdData !== 8'h00) begin failures++; $display("FAIL reset_rddata got=%h exp=00", RdData); end
        if (RdValid !== 1'b0) begin failures++; $display("FAIL reset_rdvalid2 got=%b exp=0", RdValid); end
    endtask

    task automatic test_push_fill();
        logic [W-1:0] vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) begin
            Push = 1'b1; D = vals[i];
            tick();
        end
        Push = 1'b0;
        checks += 3;
        if (Q !== 8'h44) begin failures++; $display("FAIL fill_q got=%h exp=44", Q); end
        if (Full !== 1'b1) begin failures++; $display("FAIL fill_full got=%b exp=1", Full); end
        if (Count !== 3'd4) begin failures++; $display("FAIL fill_count got=%0d exp=4", Count); end
        RdIdx = 2'd3;
        tick();
        checks += 2;
        if (RdData !== 8'h11) begin failures++; $display("FAIL fill_rd3 got=%h exp=11", RdData); end
        if (RdValid !== 1'b1) begin failures++; $display("FAIL fill_rdvalid got=%b exp=1", RdValid); end
    endtask

    task automatic test_overflow();
        Push = 1'b1; D = 8'h55; RdIdx = 2'd3;
        tick();
        Push = 1'b0;
        checks += 3;
        if (Overflow !== 1'b1) begin failures++; $display("FAIL ovf_pulse got=%b exp=1", Overflow); end
        if (Count !== 3'd4) begin failures++; $display("FAIL ovf_count got=%0d exp=4", Count); end
        if (Q !== 8'h55) begin failures++; $display("FAIL ovf_q got=%h exp=55", Q); end
        tick();
        checks += 2;
        if (Overflow !== 1'b0) begin failures++; $display("FAIL ovf_clear got=%b exp=0", Overflow); end
        if (RdData !== 8'h22) begin failures++; $display("FAIL ovf_rd3 got=%h exp=22", RdData); end
    endtask

    task automatic test_pop_underflow();
        for (int i = 0; i < 4; i++) begin
            Pop = 1'b1;
            tick();
        end
        tick();
        Pop = 1'b0;
        checks += 4;
        if (Q !== 8'h00) begin failures++; $display("FAIL unf_q got=%h exp=00", Q); end
        if (Count !== 3'd0) begin failures++; $display("FAIL unf_count got=%0d exp=0", Count); end
        if (Empty !== 1'b1) begin failures++; $display("FAIL unf_empty got=%b exp=1", Empty); end
        if (Underflow !== 1'b1) begin failures++; $display("FAIL unf_pulse got=%b exp=1", Underflow); end
        tick();
        checks += 1;
        if (Underflow !== 1'b0) begin failures++; $display("FAIL unf_clear got=%b exp=0", Underflow); end
    endtask

    task automatic test_replace_and_enable();
        Push = 1'b1; D = 8'h11; tick();
        D = 8'h22; tick();
        Pop = 1'b1; D = 8'h99; RdIdx = 2'd1; tick();
        Push = 1'b0; Pop = 1'b0;
        checks += 2;
        if (Q !== 8'h99) begin failures++; $display("FAIL repl_q got=%h exp=99", Q); end
        if (Count !== 3'd2) begin failures++; $display("FAIL repl_count got=%0d exp=2", Count); end
        tick();
        checks += 1;
        if (RdData !== 8'h11) begin failures++; $display("FAIL repl_rd1 got=%h exp=11", RdData); end
        ClockEnable = 1'b0; Push = 1'b1; D = 8'h77; tick();
        ClockEnable = 1'b1; Tick = 1'b0; Pop = 1'b1; Push = 1'b0; tick();
        idle();
        checks += 2;
        if (Q !== 8'h99) begin failures++; $display("FAIL en_q got=%h exp=99", Q); end
        if (Count !== 3'd2) begin failures++; $display("FAIL en_count got=%0d exp=2", Count); end
    endtask

    task automatic test_preset_cs();
        pre = 1'b1; tick();
        pre = 1'b0;
        checks += 2;
        if (Q !== 8'hFF) begin failures++; $display("FAIL pre_q got=%h exp=ff", Q); end
        if (Count !== 3'd4) begin failures++; $display("FAIL pre_count got=%0d exp=4", Count); end
        pre = 1'b1; Reset = 1'b0; tick();
        pre = 1'b0; Reset = 1'b1;
        checks += 2;
        if (Q !== 8'h00) begin failures++; $display("FAIL rstpre_q got=%h exp=00", Q); end
        if (Count !== 3'd0) begin failures++; $display("FAIL rstpre_count got=%0d exp=0", Count); end
        pre = 1'b1; RdIdx = 2'd2; tick();
        pre = 1'b0; tick();
        cs = 1'b1; #1;
        checks += 4;
        if (Q !== 8'hzz && Q !== 8'h00) begin failures++; $display("FAIL cs_q got=%h exp=zz", Q); end
        if (RdData !== 8'hzz && RdData !== 8'h00) begin failures++; $display("FAIL cs_rd got=%h exp=zz", RdData); end
        if (RdValid !== 1'b1) begin failures++; $display("FAIL cs_rdvalid got=%b exp=1", RdValid); end
        if (Count !== 3'd4) begin failures++; $display("FAIL cs_count got=%0d exp=4", Count); end
        cs = 1'b0; #1;
        checks += 1;
        if (RdData !== 8'hFF) begin failures++; $display("FAIL cs_off_rd got=%h exp=ff", RdData); end
    endtask

    task automatic test_random();
        logic [W-1:0] eq;
        for (int n = 0; n < 400; n++) begin
            Reset       = ($urandom_range(0, 49) != 0);
            pre         = ($urandom_range(0, 29) == 0);
            ClockEnable = ($urandom_range(0, 7) != 0);
            Tick        = ($urandom_range(0, 7) != 0);
            Push        = $urandom_range(0, 1) == 1;
            Pop         = ($urandom_range(0, 2) == 0);
            D           = W'($urandom);
            RdIdx       = IW'($urandom_range(0, 3));
            cs          = ($urandom_range(0, 9) == 0);
            tick();
            eq = (mq.size() != 0) ? mq[0] : 8'h00;
            checks += 6;
            if (Count !== CW'(mq.size())) begin failures++; $display("FAIL rnd_count n=%0d got=%0d exp=%0d", n, Count, mq.size()); end
            if (Full !== (mq.size() == DEPTH)) begin failures++; $display("FAIL rnd_full n=%0d got=%b", n, Full); end
            if (Empty !== (mq.size() == 0)) begin failures++; $display("FAIL rnd_empty n=%0d got=%b", n, Empty); end
            if (Overflow !== exp_ovf) begin failures++; $display("FAIL rnd_ovf n=%0d got=%b exp=%b", n, Overflow, exp_ovf); end
            if (Underflow !== exp_unf) begin failures++; $display("FAIL rnd_unf n=%0d got=%b exp=%b", n, Underflow, exp_unf); end
            if (RdValid !== exp_rv) begin failures++; $display("FAIL rnd_rdvalid n=%0d got=%b exp=%b", n, RdValid, exp_rv); end
            if (!cs) begin
                checks += 2;
                if (Q !== eq) begin failures++; $display("FAIL rnd_q n=%0d got=%h exp=%h", n, Q, eq); end
                if (RdData !== exp_rd) begin failures++; $display("FAIL rnd_rd n=%0d got=%h exp=%h", n, RdData, exp_rd); end
            end
        end
    endtask

    initial begin
        Reset = 1'b0; idle(); D = 8'h00; RdIdx = 2'd0;
        #2;
        test_reset();
        test_push_fill();
        test_overflow();
        test_pop_underflow();
        test_replace_and_enable();
        test_preset_cs();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
